// File: rtl/bram_ctrl.sv
// bram_ctrl
// Command-driven controller around a single-port 128-bit block RAM.
// The RAM holds four template slots, four FF slots, four TC slots and a
// sequential input-vector stream. The host pulses one command strobe while
// READY is high and then waits for READY to return.
//
// Ports
//   CLK, RST            clock (rising edge), synchronous active-high reset
//   RESET_READ_COUNTER  rewind the input-stream read pointer
//   TEMPLATE_WRITE      write template slot WRITE_DATA[127:126]
//   FF_WRITE            write FF slot of the last written template
//   TC_WRITE            write TC slot WRITE_DATA[127:126]
//   INPUT_WRITE         append WRITE_DATA to the input stream
//   WRITE_DATA          write payload
//   TEMPLATE_READ/FF_READ/TC_READ  read slot TEMPLATE_BITS
//   INPUT_READ          read the next input-stream entry
//   READ_DATA           registered read result, held until the next read
//   TEMPLATE_CHANGE     last input read changed template tag
//   READY               idle, can accept a command
module bram_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int INPUT_BASE = 16
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         RESET_READ_COUNTER,
    input  logic         INPUT_WRITE,
    input  logic         TEMPLATE_WRITE,
    input  logic         FF_WRITE,
    input  logic         TC_WRITE,
    input  logic [127:0] WRITE_DATA,
    output logic [127:0] READ_DATA,
    input  logic         TEMPLATE_READ,
    input  logic [1:0]   TEMPLATE_BITS,
    input  logic         INPUT_READ,
    input  logic         FF_READ,
    input  logic         TC_READ,
    output logic         TEMPLATE_CHANGE,
    output logic         READY
);
    // Input depth always fits in ADDR_WIDTH bits because INPUT_BASE >= 1.
    localparam int                    DEPTH   = (1 << ADDR_WIDTH) - INPUT_BASE;
    localparam logic [ADDR_WIDTH-1:0] DEPTH_P = ADDR_WIDTH'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] FF_BASE = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] TC_BASE = ADDR_WIDTH'(8);
    localparam logic [ADDR_WIDTH-1:0] IN_BASE = ADDR_WIDTH'(INPUT_BASE);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WRITE   = 2'd1;
    localparam logic [1:0] RD_ADDR = 2'd2;
    localparam logic [1:0] RD_DATA = 2'd3;

    logic [127:0]          mem [0:(1<<ADDR_WIDTH)-1];
    logic [127:0]          ram_q;
    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [127:0]          wdata_q;
    logic                  we_q;      // 0 for a dropped write to a full stream
    logic                  is_input;  // current read targets the input stream
    logic                  in_empty;  // stream was empty when the read was taken
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [1:0]            last_tmpl;
    logic [1:0]            prev_tag;

    assign READY = (state == IDLE);

    // RAM array kept free of reset so it maps onto block RAM. A write still
    // pending when RST arrives is discarded.
    always_ff @(posedge CLK) begin
        if (!RST && state == WRITE && we_q)
            mem[addr_q] <= wdata_q;
        ram_q <= mem[addr_q];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state           <= IDLE;
            READ_DATA       <= '0;
            TEMPLATE_CHANGE <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            we_q            <= 1'b0;
            is_input        <= 1'b0;
            in_empty        <= 1'b0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            last_tmpl       <= '0;
            prev_tag        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Priority chain: only the highest strobe executes.
                    if (RESET_READ_COUNTER) begin
                        rd_ptr          <= '0;
                        prev_tag        <= '0;
                        TEMPLATE_CHANGE <= 1'b0;
                    end else if (TEMPLATE_WRITE) begin
                        addr_q    <= ADDR_WIDTH'(WRITE_DATA[127:126]);
                        wdata_q   <= WRITE_DATA;
                        we_q      <= 1'b1;
                        last_tmpl <= WRITE_DATA[127:126];
                        state     <= WRITE;
                    end else if (FF_WRITE) begin
                        addr_q  <= FF_BASE + ADDR_WIDTH'(last_tmpl);
                        wdata_q <= WRITE_DATA;
                        we_q    <= 1'b1;
                        state   <= WRITE;
                    end else if (TC_WRITE) begin
                        addr_q  <= TC_BASE + ADDR_WIDTH'(WRITE_DATA[127:126]);
                        wdata_q <= WRITE_DATA;
                        we_q    <= 1'b1;
                        state   <= WRITE;
                    end else if (INPUT_WRITE) begin
                        // Full stream: run the handshake but suppress the write.
                        addr_q  <= IN_BASE + wr_ptr;
                        wdata_q <= WRITE_DATA;
                        we_q    <= (wr_ptr != DEPTH_P);
                        if (wr_ptr != DEPTH_P)
                            wr_ptr <= wr_ptr + 1'b1;
                        state   <= WRITE;
                    end else if (TEMPLATE_READ) begin
                        addr_q   <= ADDR_WIDTH'(TEMPLATE_BITS);
                        is_input <= 1'b0;
                        state    <= RD_ADDR;
                    end else if (FF_READ) begin
                        addr_q   <= FF_BASE + ADDR_WIDTH'(TEMPLATE_BITS);
                        is_input <= 1'b0;
                        state    <= RD_ADDR;
                    end else if (TC_READ) begin
                        addr_q   <= TC_BASE + ADDR_WIDTH'(TEMPLATE_BITS);
                        is_input <= 1'b0;
                        state    <= RD_ADDR;
                    end else if (INPUT_READ) begin
                        addr_q   <= IN_BASE + rd_ptr;
                        is_input <= 1'b1;
                        in_empty <= (rd_ptr == wr_ptr);
                        state    <= RD_ADDR;
                    end
                end
                WRITE:   state <= IDLE;
                RD_ADDR: state <= RD_DATA;
                RD_DATA: begin
                    if (is_input && in_empty) begin
                        READ_DATA <= '0;
                    end else begin
                        READ_DATA <= ram_q;
                        if (is_input) begin
                            TEMPLATE_CHANGE <= (ram_q[127:126] != prev_tag);
                            prev_tag        <= ram_q[127:126];
                            rd_ptr          <= rd_ptr + 1'b1;
                        end
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bram_ctrl.sv
module tb_bram_ctrl;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [8:0]   stb = '0;  // {rrc, tw, fw, tcw, iw, tr, fr, tcr, ir}, priority high->low
    logic [127:0] wdata = '0;
    logic [1:0]   tbits = '0;
    logic [127:0] rdata;
    logic         tchg, ready;

    always #5 clk = ~clk;

    bram_ctrl dut (
        .CLK(clk), .RST(rst),
        .RESET_READ_COUNTER(stb[8]), .TEMPLATE_WRITE(stb[7]), .FF_WRITE(stb[6]),
        .TC_WRITE(stb[5]), .INPUT_WRITE(stb[4]), .TEMPLATE_READ(stb[3]),
        .FF_READ(stb[2]), .TC_READ(stb[1]), .INPUT_READ(stb[0]),
        .WRITE_DATA(wdata), .READ_DATA(rdata), .TEMPLATE_BITS(tbits),
        .TEMPLATE_CHANGE(tchg), .READY(ready)
    );

    localparam logic [8:0] M_RRC = 9'h100, M_TW = 9'h080, M_FW = 9'h040, M_TCW = 9'h020,
                           M_IW = 9'h010, M_TR = 9'h008, M_FR = 9'h004, M_TCR = 9'h002,
                           M_IR = 9'h001;
    localparam logic [127:0] V1 = 128'h0123FEEDDEADBEEF0123FEEDDEADBEEF;
    localparam logic [127:0] VC = 128'hC123FEEDDEADBEEF0123FEEDDEADBEEF;
    localparam logic [127:0] V2 = 128'hFEEDDEADBEEFEEEEDDDDCCCCBBBBAAAA;

    int checks = 0, errors = 0;

    // Reference model: 12 slot words, input stream as a queue with a read index.
    logic [127:0] slot_m [0:11];
    logic [127:0] stream_m [$];
    int           rd_idx_m;
    logic [1:0]   last_m, prev_m;
    logic         tc_m;
    logic [127:0] rd_m;
    int           busy_m, got_busy;

    task automatic model_reset();
        stream_m.delete();
        rd_idx_m = 0; last_m = 0; prev_m = 0; tc_m = 0; rd_m = '0;
    endtask

    task automatic model_apply(input logic [8:0] m, input logic [127:0] d, input logic [1:0] t);
        if (m[8]) begin rd_idx_m = 0; prev_m = 0; tc_m = 0; busy_m = 0; end
        else if (m[7]) begin slot_m[d[127:126]] = d; last_m = d[127:126]; busy_m = 1; end
        else if (m[6]) begin slot_m[4 + last_m] = d; busy_m = 1; end
        else if (m[5]) begin slot_m[8 + d[127:126]] = d; busy_m = 1; end
        else if (m[4]) begin if (stream_m.size() < 240) stream_m.push_back(d); busy_m = 1; end
        else if (m[3]) begin rd_m = slot_m[t]; busy_m = 2; end
        else if (m[2]) begin rd_m = slot_m[4 + t]; busy_m = 2; end
        else if (m[1]) begin rd_m = slot_m[8 + t]; busy_m = 2; end
        else if (m[0]) begin
            busy_m = 2;
            if (rd_idx_m == stream_m.size()) rd_m = '0;
            else begin
                rd_m = stream_m[rd_idx_m];
                tc_m = (rd_m[127:126] != prev_m);
                prev_m = rd_m[127:126];
                rd_idx_m++;
            end
        end
    endtask

    // Pulse a command for one cycle, then poll READY (bounded) counting busy cycles.
    task automatic cmd(input logic [8:0] m, input logic [127:0] d, input logic [1:0] t);
        model_apply(m, d, t);
        @(negedge clk);
        stb = m; wdata = d; tbits = t;
        @(negedge clk);
        stb = '0;
        got_busy = 0;
        while (!ready && got_busy < 20) begin
            got_busy++;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
        checks++; if (rdata !== '0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata); end
        checks++; if (tchg !== 1'b0) begin errors++; $display("FAIL reset_tchg got %b want 0", tchg); end
    endtask

    task automatic test_tc();
        cmd(M_TCW, V1, 0);
        checks++; if (got_busy !== 1) begin errors++; $display("FAIL tc_write_busy got %0d want 1", got_busy); end
        cmd(M_TCR, '0, 0);
        checks++; if (got_busy !== 2) begin errors++; $display("FAIL tc_read_busy got %0d want 2", got_busy); end
        checks++; if (rdata !== V1) begin errors++; $display("FAIL tc_read got %h want %h", rdata, V1); end
    endtask

    task automatic test_template_ff();
        logic [127:0] z;
        z = 128'h0000_1111_2222_3333_4444_5555_6666_7777;
        cmd(M_TW, V1, 0);
        cmd(M_FW, z, 0);           // FF slot 0
        cmd(M_TW, VC, 0);          // template 3, now last written
        cmd(M_FW, V1, 0);          // FF slot 3
        cmd(M_TR, '0, 3);
        checks++; if (rdata !== VC) begin errors++; $display("FAIL tmpl3 got %h want %h", rdata, VC); end
        cmd(M_TR, '0, 0);
        checks++; if (rdata !== V1) begin errors++; $display("FAIL tmpl0 got %h want %h", rdata, V1); end
        cmd(M_FR, '0, 3);
        checks++; if (rdata !== V1) begin errors++; $display("FAIL ff3 got %h want %h", rdata, V1); end
        cmd(M_FR, '0, 0);
        checks++; if (rdata !== z) begin errors++; $display("FAIL ff0 got %h want %h", rdata, z); end
    endtask

    task automatic test_input();
        cmd(M_IW, V1, 0);
        cmd(M_IW, V2, 0);
        cmd(M_IR, '0, 0);
        checks++; if (rdata !== V1 || tchg !== 1'b0) begin errors++; $display("FAIL in_rd0 got %h/%b want %h/0", rdata, tchg, V1); end
        cmd(M_IR, '0, 0);
        checks++; if (rdata !== V2 || tchg !== 1'b1) begin errors++; $display("FAIL in_rd1 got %h/%b want %h/1", rdata, tchg, V2); end
        // Stream now exhausted: zero data, TEMPLATE_CHANGE held.
        cmd(M_IR, '0, 0);
        checks++; if (rdata !== '0 || tchg !== 1'b1 || got_busy !== 2) begin
            errors++; $display("FAIL in_empty got %h/%b busy %0d want 0/1 busy 2", rdata, tchg, got_busy); end
        cmd(M_RRC, '0, 0);
        checks++; if (got_busy !== 0 || tchg !== 1'b0) begin errors++; $display("FAIL rrc got busy %0d tchg %b want 0/0", got_busy, tchg); end
        cmd(M_IR, '0, 0);
        checks++; if (rdata !== V1 || tchg !== 1'b0) begin errors++; $display("FAIL in_rewind got %h/%b want %h/0", rdata, tchg, V1); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 241; i++)
            cmd(M_IW, {2'(i), 94'd0, 32'(i)}, 0);
        for (int i = 0; i < 241; i++) begin
            cmd(M_IR, '0, 0);
            checks++; if (rdata !== rd_m || tchg !== tc_m) begin
                errors++; $display("FAIL full_rd%0d got %h/%b want %h/%b", i, rdata, tchg, rd_m, tc_m); end
        end
    endtask

    task automatic test_busy_ignore();
        logic [127:0] keep;
        keep = slot_m[8];
        @(negedge clk);
        stb = M_TCR; tbits = 0;
        @(negedge clk);
        stb = '0;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL poll_ready got %b want 0", ready); end
        stb = M_TCW; wdata = V2 & ~(128'h3 << 126);  // tag 0, would overwrite TC slot 0
        @(negedge clk);
        stb = '0;
        for (int i = 0; i < 20 && !ready; i++) @(negedge clk);
        checks++; if (rdata !== keep) begin errors++; $display("FAIL busy_rd got %h want %h", rdata, keep); end
        cmd(M_TCR, '0, 0);
        checks++; if (rdata !== keep) begin errors++; $display("FAIL busy_ignored got %h want %h", rdata, keep); end
    endtask

    task automatic test_priority();
        logic [127:0] d;
        do_reset();
        d = {2'd2, 126'h2AAA_5555_0F0F};
        cmd(M_TW | M_IW, d, 0);
        cmd(M_TR, '0, 2);
        checks++; if (rdata !== d) begin errors++; $display("FAIL prio_tmpl got %h want %h", rdata, d); end
        cmd(M_IR, '0, 0);
        checks++; if (rdata !== '0) begin errors++; $display("FAIL prio_noinput got %h want 0", rdata); end
    endtask

    task automatic test_reset_mid_read();
        cmd(M_TR, '0, 2);  // leaves READ_DATA non-zero
        @(negedge clk);
        stb = M_TR; tbits = 3;
        @(negedge clk);
        stb = '0; rst = 1'b1;
        @(negedge clk);
        checks++; if (ready !== 1'b1 || rdata !== '0) begin
            errors++; $display("FAIL rst_mid got ready %b rdata %h want 1/0", ready, rdata); end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        logic [8:0]   m;
        logic [127:0] d;
        do_reset();
        for (int t = 0; t < 4; t++) begin
            cmd(M_TW, {2'(t), 94'($urandom), 32'($urandom)}, 0);
            cmd(M_FW, {$urandom, $urandom, $urandom, $urandom}, 0);
            cmd(M_TCW, {2'(t), 94'($urandom), 32'($urandom)}, 0);
        end
        for (int n = 0; n < 300; n++) begin
            m = 9'(1) << $urandom_range(1, 8);
            if ($urandom_range(0, 2) == 0) m = 9'(1) << $urandom_range(0, 8);
            if ($urandom_range(0, 3) == 0) m = m | (9'(1) << $urandom_range(0, 7));
            if ($urandom_range(0, 1) == 0) m = M_IR;
            d = {$urandom, $urandom, $urandom, $urandom};
            cmd(m, d, 2'($urandom_range(0, 3)));
            checks++; if (rdata !== rd_m || tchg !== tc_m || got_busy !== busy_m) begin
                errors++;
                $display("FAIL rand%0d mask %h got %h/%b busy %0d want %h/%b busy %0d",
                         n, m, rdata, tchg, got_busy, rd_m, tc_m, busy_m);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_tc();
        test_template_ff();
        test_input();
        test_busy_ignore();
        test_full();
        test_priority();
        test_reset_mid_read();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
